// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin grant with address-phase lock,
// and an in-order master-ID FIFO that routes each response to its issuer.
module obi_rr_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_be,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic                              s_req,
  output logic                              s_we,
  output logic [DATA_W/8-1:0]               s_be,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic [DATA_W-1:0]                 s_wdata,
  input  logic                              s_gnt,
  input  logic                              s_rvalid,
  input  logic [DATA_W-1:0]                 s_rdata,
  output logic                              err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [IDX_W-1:0] id_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [IDX_W-1:0] rr_sel, sel, head_id;
  logic             fifo_full, fifo_empty;
  logic             hs, push, pop;

  // First requester at or after ptr, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = ptr;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (req[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_master(input logic [IDX_W-1:0] cur);
    if (int'(cur) == NUM_MASTERS - 1) return '0;
    return cur + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
    if (MAX_OUTSTANDING == 1) return '0;
    return p + 1'b1;
  endfunction

  assign rr_sel     = rr_pick(m_req, rr_ptr_q);
  assign sel        = lock_q ? lock_id_q : rr_sel;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem_q[rd_ptr_q];

  // Full is judged on the registered count only, so rvalid never reaches s_req.
  assign s_req   = ~rst & m_req[sel] & ~fifo_full;
  assign s_we    = m_we[sel];
  assign s_be    = m_be[int'(sel)*BE_W +: BE_W];
  assign s_addr  = m_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[int'(sel)*DATA_W +: DATA_W];

  assign hs      = s_req & s_gnt;
  assign push    = hs;
  assign pop     = s_rvalid & ~fifo_empty;
  assign m_rdata = s_rdata;
  assign err     = err_q;

  always_comb begin
    m_gnt = '0;
    if (hs) m_gnt[sel] = 1'b1;
  end

  always_comb begin
    m_rvalid = '0;
    if (pop) m_rvalid[head_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      rr_ptr_d = next_master(sel);
      lock_d   = 1'b0;
    end else if (s_req) begin
      // Stalled address phase: pin the choice until the slave takes it.
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      if (push) wr_ptr_q <= fifo_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= fifo_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (s_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // ID storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_obi_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;
  localparam int MO  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_we;
  logic [N*BEW-1:0] m_be;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt, m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_we;
  logic [BEW-1:0]  s_be;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_gnt, s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mq[$];
  int m_rr      = 0;
  bit m_lock    = 1'b0;
  int m_lock_id = 0;
  bit m_err     = 1'b0;

  obi_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: expected outputs from the arbitration rules, then advance state.
  always @(negedge clk) begin
    int           sel;
    bit           found, full, empty, ereq;
    logic [N-1:0] egnt, erv;
    if (rst) begin
      mq.delete();
      m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
    end
    full  = (mq.size() == MO);
    empty = (mq.size() == 0);
    if (m_lock) sel = m_lock_id;
    else begin
      sel = m_rr; found = 1'b0;
      for (int k = 0; k < N; k++)
        if (!found && m_req[(m_rr + k) % N]) begin sel = (m_rr + k) % N; found = 1'b1; end
    end
    ereq = !rst && m_req[sel] && !full;
    egnt = '0;
    if (ereq && s_gnt) egnt[sel] = 1'b1;
    erv = '0;
    if (!rst && s_rvalid && !empty) erv[mq[0]] = 1'b1;
    chk("s_req", 128'(s_req), 128'(ereq));
    chk("m_gnt", 128'(m_gnt), 128'(egnt));
    chk("m_rvalid", 128'(m_rvalid), 128'(erv));
    chk("err", 128'(err), 128'(m_err));
    if (ereq)
      chk("s_fwd", 128'({s_we, s_be, s_addr, s_wdata}),
          128'({m_we[sel], m_be[sel*BEW +: BEW], m_addr[sel*AW +: AW], m_wdata[sel*DW +: DW]}));
    if (erv != '0) chk("m_rdata", 128'(m_rdata), 128'(s_rdata));
    if (!rst) begin
      if (s_rvalid && empty) m_err = 1'b1;
      if (s_rvalid && !empty) void'(mq.pop_front());
      if (ereq && s_gnt) begin
        mq.push_back(sel);
        m_rr   = (sel + 1) % N;
        m_lock = 1'b0;
      end else if (ereq) begin
        m_lock    = 1'b1;
        m_lock_id = sel;
      end
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] req, input logic g, input logic rv);
    @(posedge clk);
    #1;
    rst = r; m_req = req; s_gnt = g; s_rvalid = rv; s_rdata = $urandom;
    #2;
  endtask

  initial begin
    logic [15:0]  gpat, rpat;
    logic [N-1:0] g, pend;

    rst = 1'b1; m_req = '1; m_we = '0; m_be = '1; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = AW'((i + 1) * 32'h100);
      m_wdata[i*DW +: DW] = DW'(i);
    end
    #3;
    chk("rst_sreq", 128'(s_req), 128'(1'b0));
    chk("rst_gnt", 128'(m_gnt), 128'(4'b0000));
    chk("rst_err", 128'(err), 128'(1'b0));
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
    chk("rst_all", 128'({s_req, m_gnt, m_rvalid, err}), 128'(10'd0));
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_rel_err", 128'(err), 128'(1'b0));

    // Two contenders, slave answers one cycle after each grant
    gpat = 16'h2121; rpat = 16'h1210;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0011, 1'b1, i > 0);
      chk("t1_gnt", 128'(m_gnt), 128'(gpat[i*4 +: 4]));
      chk("t1_rv", 128'(m_rvalid), 128'(rpat[i*4 +: 4]));
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t1_last_rv", 128'(m_rvalid), 128'(4'b0010));

    // Move pointer to master 1 so the lock is what keeps master 0 selected
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("t2_pre_gnt", 128'(m_gnt), 128'(4'b0001));
    drive(1'b0, 4'b0001, 1'b0, 1'b1);
    chk("t2_c1_addr", 128'(s_addr), 128'(32'h100));
    chk("t2_c1_rv", 128'(m_rvalid), 128'(4'b0001));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b0011, 1'b0, 1'b0);
      chk("t2_hold_addr", 128'(s_addr), 128'(32'h100));
      chk("t2_hold_gnt", 128'(m_gnt), 128'(4'b0000));
    end
    drive(1'b0, 4'b0011, 1'b1, 1'b0);
    chk("t2_c4_gnt", 128'(m_gnt), 128'(4'b0001));
    chk("t2_c4_addr", 128'(s_addr), 128'(32'h100));
    drive(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("t2_c5_gnt", 128'(m_gnt), 128'(4'b0010));
    chk("t2_c5_addr", 128'(s_addr), 128'(32'h200));
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t2_rv0", 128'(m_rvalid), 128'(4'b0001));
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t2_rv1", 128'(m_rvalid), 128'(4'b0010));

    // FIFO full blocks further requests, including the cycle of the pop
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("t3_g1", 128'(m_gnt), 128'(4'b0001));
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("t3_g2", 128'(m_gnt), 128'(4'b0001));
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("t3_full_sreq", 128'(s_req), 128'(1'b0));
    drive(1'b0, 4'b0001, 1'b1, 1'b1);
    chk("t3_pop_sreq", 128'(s_req), 128'(1'b0));
    chk("t3_pop_rv", 128'(m_rvalid), 128'(4'b0001));
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("t3_resume", 128'({s_req, m_gnt}), 128'(5'b10001));
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);

    // Spurious response
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t4_rv", 128'(m_rvalid), 128'(4'b0000));
    chk("t4_err_now", 128'(err), 128'(1'b0));
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("t4_err_set", 128'(err), 128'(1'b1));
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("t4_err_sticky", 128'(err), 128'(1'b1));

    // Reset while responses are in flight
    drive(1'b0, 4'b0010, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("t5_g2", 128'(m_gnt), 128'(4'b0010));
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t5_rv", 128'(m_rvalid), 128'(4'b0010));
    drive(1'b1, 4'b0010, 1'b1, 1'b1);
    chk("t5_rst_outs", 128'({s_req, m_gnt, m_rvalid, err}), 128'(10'd0));
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("t5_rel_err", 128'(err), 128'(1'b0));
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t5_late_rv", 128'(m_rvalid), 128'(4'b0000));
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("t5_late_err", 128'(err), 128'(1'b1));
    drive(1'b1, 4'b0000, 1'b0, 1'b0);

    // Sparse requesters 1 and 3
    gpat = 16'h8282; rpat = 16'h2820;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1010, 1'b1, i > 0);
      chk("t6_gnt", 128'(m_gnt), 128'(gpat[i*4 +: 4]));
      chk("t6_rv", 128'(m_rvalid), 128'(rpat[i*4 +: 4]));
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("t6_last_rv", 128'(m_rvalid), 128'(4'b1000));

    // Random traffic: masters hold requests until granted, rare withdrawals and resets
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      g = m_gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) pend[i] = 1'b0;
        else if (pend[i] && ($urandom % 100 == 0)) pend[i] = 1'b0;
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          m_addr[i*AW +: AW]   = $urandom;
          m_we[i]              = 1'($urandom);
          m_be[i*BEW +: BEW]   = BEW'($urandom);
          m_wdata[i*DW +: DW]  = $urandom;
        end
      end
      m_req    = pend;
      rst      = ($urandom % 400 == 0);
      s_gnt    = ($urandom % 3 != 0);
      s_rvalid = ((mq.size() > 0) && ($urandom % 2 == 0)) || ($urandom % 300 == 0);
      s_rdata  = $urandom;
      #2;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Parametrised N-master to 1-slave OBI (req/gnt/rvalid) arbiter.
- Lets several core-side ports (instruction fetch, data, a future DMA) share one bus slave port.
- Fair round-robin selection, with the address phase held stable while a request waits.
- A master-ID FIFO tracks up to MAX_OUTSTANDING in-order transactions and routes each response back to its issuing master.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- MAX_OUTSTANDING, 2, depth of the ID FIFO (power of two, >=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- m_req  in  NUM_MASTERS  per-master request
- m_we  in  NUM_MASTERS  per-master write enable
- m_be  in  NUM_MASTERS*DATA_W/8  byte enables, master i at slice i
- m_addr  in  NUM_MASTERS*ADDR_W  addresses, master i at slice i
- m_wdata  in  NUM_MASTERS*DATA_W  write data, master i at slice i
- m_gnt  out  NUM_MASTERS  one-hot grant
- m_rvalid  out  NUM_MASTERS  one-hot response valid
- m_rdata  out  DATA_W  read data, broadcast to all masters
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_be  out  DATA_W/8  slave byte enables
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_gnt  in  1  slave grant
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_W  slave read data
- err  out  1  sticky: rvalid received with no transaction outstanding

Behaviour:
- Reset (async, rst=1): rr_ptr=0, lock=0, FIFO empty, err=0. All outputs 0: s_req, m_gnt, m_rvalid, err.
- Selection, when lock=0:
  - sel = first i with m_req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - If no master requests, s_req=0.
- Lock:
  - If s_req=1 and s_gnt=0 at a clock edge, set lock=1 and lock_id=sel.
  - While locked, sel=lock_id regardless of other requests.
  - lock clears on the handshake.
- Forwarding is combinational:
  - s_req = m_req[sel] & ~fifo_full.
  - s_we/s_be/s_addr/s_wdata = slice sel.
- Grant:
  - m_gnt[sel] = s_gnt & s_req; all other grant bits 0.
  - Handshake = s_req & s_gnt.
  - On handshake: push sel into FIFO, rr_ptr <= (sel+1) mod NUM_MASTERS, lock <= 0.
- Response path, zero latency:
  - m_rvalid[fifo_head] = s_rvalid & ~fifo_empty.
  - m_rdata = s_rdata, broadcast.
  - FIFO pops on s_rvalid & ~fifo_empty.
- Response with empty FIFO: s_rvalid while empty is dropped, with no m_rvalid, and sets err=1. err clears only on reset.
- FIFO full:
  - s_req is forced to 0 even if s_rvalid pops in the same cycle; no combinational rvalid->req path.
  - Arbitration resumes the cycle after the count drops.
- Same-cycle push and pop (not full): both take effect and the count is unchanged.
- Order: the slave responds in order. Pointers wrap modulo MAX_OUTSTANDING; the count is a separate counter of width clog2(MAX_OUTSTANDING)+1.
- Master withdraws m_req while locked: this is a protocol violation. The arbiter keeps lock_id, drives s_req=0 and waits for that request to reappear. It does not deadlock on reset.
- Reset mid-transaction: all state clears immediately, and in-flight responses arriving after reset set err.

Test Plan:
1. NUM_MASTERS=2, both m_req=1 continuously, s_gnt=1, s_rvalid one cycle after each grant -> m_gnt alternates 01,10,01,10; every response lands on the master granted one cycle earlier.
2. Master 0 requests addr 0x100 with s_gnt=0 for 3 cycles; master 1 asserts req on cycle 2 -> s_addr stays 0x100 and m_gnt[1]=0 throughout; grant goes to master 0 on cycle 4, master 1 is granted next.
3. MAX_OUTSTANDING=2, s_gnt=1, s_rvalid=0 -> exactly 2 grants, then s_req=0. s_rvalid=1 for one cycle -> s_req returns the following cycle.
4. Pulse s_rvalid with no outstanding transaction -> no m_rvalid bit set; err=1 from the next cycle until rst.
5. Issue 2 reads from master 1, then assert rst for one cycle mid-response -> all outputs 0 while rst=1; FIFO empty; err=0 after release.
6. NUM_MASTERS=4, only masters 1 and 3 requesting -> grant order 1,3,1,3 with rr_ptr skipping idle masters 0 and 2.
